// File: rtl/filt_pkg.sv
// Shared definitions for the multi-channel glitch filter: state encoding,
// default thresholds and the layout of an event record {chan, rise}.
package filt_pkg;

  localparam logic LOW  = 1'b0;
  localparam logic HIGH = 1'b1;

  typedef enum logic {
    S_LOW  = LOW,
    S_HIGH = HIGH
  } state_t;

  localparam int FILT_ON_DEF  = 3;
  localparam int FILT_OFF_DEF = 3;

  // Event record is {chan, rise}: polarity in bit 0, channel index above it.
  localparam int EV_RISE_BIT = 0;
  localparam int EV_CHAN_LSB = 1;

endpackage

// File: rtl/filt_chan.sv
// One run-length glitch filter; y flips on the edge sampling the threshold-th
// consecutive opposite input, ev/ev_rise flag that same cycle combinationally.
module filt_chan
  import filt_pkg::*;
#(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i,
  input  logic [CW-1:0] on_th,
  input  logic [CW-1:0] off_th,
  input  logic          clr,
  output logic          y,
  output logic          ev,
  output logic          ev_rise
);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] th_sel;
  logic [CW:0]   th_eff;
  logic [CW:0]   cnt_inc;
  logic          match;
  logic          hit;

  // A programmed threshold of zero behaves as one.
  always_comb begin
    th_sel  = (state == S_LOW) ? on_th : off_th;
    th_eff  = (th_sel == '0) ? (CW+1)'(1) : {1'b0, th_sel};
    cnt_inc = {1'b0, cnt} + (CW+1)'(1);
    match   = (state == S_LOW) ? i : ~i;
    hit     = match && (cnt_inc == th_eff);
  end

  // A threshold load in the same cycle suppresses the transition.
  assign ev      = hit && !clr;
  assign ev_rise = (state == S_LOW);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_LOW;
      y     <= 1'b0;
      cnt   <= '0;
    end else if (clr || !match) begin
      cnt <= '0;
    end else if (hit) begin
      state <= (state == S_LOW) ? S_HIGH : S_LOW;
      y     <= (state == S_LOW);
      cnt   <= '0;
    end else begin
      cnt <= cnt_inc[CW-1:0];
    end
  end

endmodule

// File: rtl/filt_sched.sv
// N glitch filters feeding per-channel pending flags and a round-robin event port;
// event reaches ev_valid one cycle after the filtered edge, held stable while !ev_ready.
module filt_sched
  import filt_pkg::*;
#(
  parameter int N       = 4,
  parameter int CW      = 3,
  parameter int ON_DEF  = FILT_ON_DEF,
  parameter int OFF_DEF = FILT_OFF_DEF,
  localparam int CHW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   i,
  input  logic           cfg_we,
  input  logic [CW-1:0]  cfg_on,
  input  logic [CW-1:0]  cfg_off,
  output logic [N-1:0]   y,
  output logic           ev_valid,
  input  logic           ev_ready,
  output logic [CHW-1:0] ev_chan,
  output logic           ev_rise,
  output logic           ev_drop
);

  logic [CW-1:0]  on_th;
  logic [CW-1:0]  off_th;
  logic [N-1:0]   ch_ev;
  logic [N-1:0]   ch_rise;
  logic [N-1:0]   pend;
  logic [N-1:0]   pend_rise;
  logic [N-1:0]   taken;
  logic [CHW-1:0] rr;
  logic [CHW-1:0] sel;
  logic [CHW-1:0] rr_nxt;
  logic [CHW:0]   idx_w;
  logic [CHW-1:0] idx;
  logic           found;
  logic           load_en;
  logic [CHW:0]   out_q;

  for (genvar g = 0; g < N; g++) begin : g_chan
    filt_chan #(
      .CW(CW)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .i      (i[g]),
      .on_th  (on_th),
      .off_th (off_th),
      .clr    (cfg_we),
      .y      (y[g]),
      .ev     (ch_ev[g]),
      .ev_rise(ch_rise[g])
    );
  end

  assign load_en = !ev_valid || ev_ready;

  // First pending channel at or after rr, wrapping modulo N.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx_w = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx_w = {1'b0, rr} + (CHW+1)'(k);
      if (idx_w >= (CHW+1)'(N)) begin
        idx_w = idx_w - (CHW+1)'(N);
      end
      idx = idx_w[CHW-1:0];
      if (!found && pend[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    taken = '0;
    if (load_en && found) begin
      taken[sel] = 1'b1;
    end
    rr_nxt = (sel == CHW'(N - 1)) ? '0 : sel + 1'b1;
  end

  assign ev_chan = out_q[EV_CHAN_LSB +: CHW];
  assign ev_rise = out_q[EV_RISE_BIT];

  // A channel being loaded this cycle can take a fresh event without a drop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      on_th     <= CW'(ON_DEF);
      off_th    <= CW'(OFF_DEF);
      pend      <= '0;
      pend_rise <= '0;
      ev_valid  <= 1'b0;
      ev_drop   <= 1'b0;
      out_q     <= '0;
      rr        <= '0;
    end else begin
      if (cfg_we) begin
        on_th  <= cfg_on;
        off_th <= cfg_off;
      end
      pend      <= (pend & ~taken) | ch_ev;
      pend_rise <= (pend_rise & ~ch_ev) | (ch_rise & ch_ev);
      ev_drop   <= |(ch_ev & pend & ~taken);
      if (load_en) begin
        if (found) begin
          ev_valid <= 1'b1;
          out_q    <= {sel, pend_rise[sel]};
          rr       <= rr_nxt;
        end else begin
          ev_valid <= 1'b0;
        end
      end
    end
  end

endmodule
